hub75_scan_controller: RTL and testbench



---
 rtl/hub75_scan_controller.sv | 195 +++++++++++++++++++
 tb/tb_hub75_scan_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_controller.sv
// HUB75 scan controller: walks rows and 2 BCM planes of a 1024x8 framebuffer,
// shifting 32 column pairs per plane, latching, then lighting the row.
// Ports: clk, reset_n (async low), enable; RAM read port (ram_read_addr,
// ram_read_en, ram_read_data); panel pins hub_{r,g,b}{0,1}, hub_addr,
// hub_clk, hub_lat, hub_oe_n; frame_done pulse at end of each frame.
module hub75_scan_controller #(
  parameter int BASE_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] ram_read_addr,
  output logic       ram_read_en,
  input  logic [7:0] ram_read_data,
  output logic       hub_r0,
  output logic       hub_g0,
  output logic       hub_b0,
  output logic       hub_r1,
  output logic       hub_g1,
  output logic       hub_b1,
  output logic [3:0] hub_addr,
  output logic       hub_clk,
  output logic       hub_lat,
  output logic       hub_oe_n,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_DISP
  } state_t;

  localparam logic [15:0] BT = 16'(BASE_TICKS);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic        plane_q, plane_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  ph_q, ph_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] limit;
  logic [7:0]  top_q, top_d;
  logic [2:0]  rgb0_q, rgb0_d;
  logic [2:0]  rgb1_q, rgb1_d;
  logic [9:0]  addr_q, addr_d;
  logic        ren_q, ren_d;
  logic [3:0]  haddr_q, haddr_d;
  logic        hclk_q, hclk_d;
  logic        lat_q, lat_d;
  logic        oe_n_q, oe_n_d;
  logic        done_q, done_d;

  function automatic logic [2:0] pick(
    input logic [7:0] px,
    input logic       pl
  );
    pick = pl ? {px[5], px[3], px[1]}
              : {px[4], px[2], px[0]};
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    col_d   = col_q;
    ph_d    = ph_q;
    tick_d  = tick_q;
    top_d   = top_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    done_d  = 1'b0;
    limit   = plane_q ? {BT[14:0], 1'b0} : BT;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          row_d   = 4'd0;
          plane_d = 1'b0;
          col_d   = 5'd0;
          ph_d    = 3'd0;
        end
      end
      S_SHIFT: begin
        // Data for the top address arrives in ph1, bottom in ph2.
        if (ph_q == 3'd1) top_d = ram_read_data;
        if (ph_q == 3'd2) begin
          rgb0_d = pick(top_q, plane_q);
          rgb1_d = pick(ram_read_data, plane_q);
        end
        if (ph_q == 3'd4) begin
          ph_d = 3'd0;
          if (col_q == 5'd31) begin
            state_d = S_LATCH;
            col_d   = 5'd0;
          end else begin
            col_d = col_q + 5'd1;
          end
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_LATCH: begin
        state_d = S_DISP;
        tick_d  = 16'd0;
      end
      S_DISP: begin
        if (tick_q == limit - 16'd1) begin
          tick_d = 16'd0;
          ph_d   = 3'd0;
          col_d  = 5'd0;
          if (!plane_q) begin
            plane_d = 1'b1;
            state_d = S_SHIFT;
          end else if (row_q != 4'd15) begin
            plane_d = 1'b0;
            row_d   = row_q + 4'd1;
            state_d = S_SHIFT;
          end else begin
            done_d  = 1'b1;
            row_d   = 4'd0;
            plane_d = 1'b0;
            state_d = enable ? S_SHIFT : S_IDLE;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the state being entered.
    ren_d  = (state_d == S_SHIFT);
    addr_d = addr_q;
    if (state_d == S_SHIFT && ph_d == 3'd0)
      addr_d = {row_d, col_d, 1'b0};
    else if (state_d == S_SHIFT && ph_d == 3'd1)
      addr_d = {row_d, col_d, 1'b1};
    hclk_d  = (state_d == S_SHIFT) && (ph_d == 3'd4);
    lat_d   = (state_d == S_LATCH);
    haddr_d = lat_d ? row_d : haddr_q;
    oe_n_d  = (state_d != S_DISP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= 4'd0;
      plane_q <= 1'b0;
      col_q   <= 5'd0;
      ph_q    <= 3'd0;
      tick_q  <= 16'd0;
      top_q   <= 8'd0;
      rgb0_q  <= 3'd0;
      rgb1_q  <= 3'd0;
      addr_q  <= 10'd0;
      ren_q   <= 1'b0;
      haddr_q <= 4'd0;
      hclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      ph_q    <= ph_d;
      tick_q  <= tick_d;
      top_q   <= top_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      haddr_q <= haddr_d;
      hclk_q  <= hclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      done_q  <= done_d;
    end
  end

  assign ram_read_addr = addr_q;
  assign ram_read_en   = ren_q;
  assign {hub_r0, hub_g0, hub_b0} = rgb0_q;
  assign {hub_r1, hub_g1, hub_b1} = rgb1_q;
  assign hub_addr   = haddr_q;
  assign hub_clk    = hclk_q;
  assign hub_lat    = lat_q;
  assign hub_oe_n   = oe_n_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Scoreboard bench for hub75_scan_controller with a 1-cycle-latency RAM model.
// Expected pixels, latches, OE runs and frame_done times are queued and popped by a monitor.
module tb_hub75_scan_controller;

  localparam int BT    = 4;
  localparam int ROWC  = 322 + 3 * BT;
  localparam int FRAME = 16 * ROWC;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [9:0] ram_read_addr;
  logic       ram_read_en;
  logic [7:0] ram_read_data = 8'h00;
  logic       hub_r0, hub_g0, hub_b0;
  logic       hub_r1, hub_g1, hub_b1;
  logic [3:0] hub_addr;
  logic       hub_clk, hub_lat, hub_oe_n, frame_done;

  hub75_scan_controller #(.BASE_TICKS(BT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .ram_read_addr(ram_read_addr),
    .ram_read_en(ram_read_en),
    .ram_read_data(ram_read_data),
    .hub_r0(hub_r0),
    .hub_g0(hub_g0),
    .hub_b0(hub_b0),
    .hub_r1(hub_r1),
    .hub_g1(hub_g1),
    .hub_b1(hub_b1),
    .hub_addr(hub_addr),
    .hub_clk(hub_clk),
    .hub_lat(hub_lat),
    .hub_oe_n(hub_oe_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [1024];
  always @(posedge clk)
    if (ram_read_en) ram_read_data <= mem[ram_read_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [5:0]  q_rgb [$];
  logic [3:0]  q_lat [$];
  int          q_oe  [$];
  int unsigned q_done[$];
  bit mon_en = 1'b0;
  int oe_run = 0;
  int done_cnt = 0;

  // Monitor: pops and compares whenever the panel side presents an event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hub_clk) begin
        if (q_rgb.size() == 0) chk("rgb_unexpected", 1, 0);
        else chk("rgb", {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1},
                 q_rgb.pop_front());
      end
      if (hub_lat) begin
        if (q_lat.size() == 0) chk("lat_unexpected", 1, 0);
        else chk("lat_row", hub_addr, q_lat.pop_front());
        chk("lat_oe_n", hub_oe_n, 1);
      end
      if (!hub_oe_n) begin
        oe_run++;
        chk("oe_exclusive", {ram_read_en, hub_lat, hub_clk}, 0);
      end else if (oe_run > 0) begin
        if (q_oe.size() == 0) chk("oe_unexpected", 1, 0);
        else chk("oe_run_len", oe_run, q_oe.pop_front());
        oe_run = 0;
      end
      if (frame_done) begin
        done_cnt++;
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("frame_done_cyc", int'(cyc), int'(q_done.pop_front()));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, ram_read_addr, 0);
    chk({tag, "_ren"}, ram_read_en, 0);
    chk({tag, "_rgb"}, {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1}, 0);
    chk({tag, "_haddr"}, hub_addr, 0);
    chk({tag, "_hclk"}, hub_clk, 0);
    chk({tag, "_lat"}, hub_lat, 0);
    chk({tag, "_oe_n"}, hub_oe_n, 1);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    logic [7:0]  tp, bm;
    int unsigned t0, target;
    int          w;
    reset_n = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[206] = 8'h2A;
    mem[207] = 8'h15;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_oe_n", hub_oe_n, 1);
    chk("idle_ren", ram_read_en, 0);

    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 16; r++)
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < 32; c++) begin
            tp = mem[r * 64 + c * 2];
            bm = mem[r * 64 + c * 2 + 1];
            q_rgb.push_back({tp[4 + p], tp[2 + p], tp[p],
                             bm[4 + p], bm[2 + p], bm[p]});
          end
          q_lat.push_back(4'(r));
          q_oe.push_back(BT << p);
        end

    t0 = cyc;
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) q_done.push_back(t0 + 1 + k * FRAME);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hclk_c%0d", i), hub_clk, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("ren_c%0d", i), ram_read_en, 1);
      if (i == 0) chk("addr_c0", ram_read_addr, 0);
      if (i == 1) chk("addr_c1", ram_read_addr, 1);
      if (i == 5) chk("addr_c5", ram_read_addr, 2);
      if (i == 6) chk("addr_c6", ram_read_addr, 3);
    end

    target = t0 + 1 + 2 * FRAME + 8 * ROWC;
    while (cyc < target) @(negedge clk);
    enable = 1'b0;

    while (done_cnt < 3 && cyc < t0 + 3 * FRAME + 200) @(negedge clk);
    chk("frames_done", done_cnt, 3);

    repeat (20) begin
      @(negedge clk);
      chk("post_idle_oe_n", hub_oe_n, 1);
      chk("post_idle_ren", ram_read_en, 0);
    end
    chk("q_rgb_left", q_rgb.size(), 0);
    chk("q_lat_left", q_lat.size(), 0);
    chk("q_oe_left", q_oe.size(), 0);
    chk("q_done_left", q_done.size(), 0);
    mon_en = 1'b0;

    enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("pre_reset_ren", ram_read_en, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    w = 0;
    while (!ram_read_en && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("restart_ren", ram_read_en, 1);
    chk("restart_addr", ram_read_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
